// File: rtl/vga_sync_gen_if.sv
// Timing bundle from the VGA sync generator to the text/font pixel stage.
// There is no handshake: the consumer samples every clk and may use p_tick
// as its enable. master = generator side, slave = consumer side.
interface vga_sync_gen_if;
    logic       p_tick;
    logic [9:0] pixel_x;
    logic [9:0] pixel_y;
    logic       video_on;
    logic       hsync;
    logic       vsync;
    logic       line_start;
    logic       frame_start;

    modport master (
        output p_tick, pixel_x, pixel_y, video_on,
        output hsync, vsync, line_start, frame_start
    );

    modport slave (
        input p_tick, pixel_x, pixel_y, video_on,
        input hsync, vsync, line_start, frame_start
    );
endinterface

// File: rtl/vga_sync_gen.sv
// VGA timing generator: divides clk into a pixel tick, runs the horizontal
// and vertical scan counters and produces registered sync/blanking flags
// that line up with pixel_x/pixel_y in the same cycle.
// Reset parks the counters on the last blanking pixel of a frame, so the
// first pixel tick after release wraps cleanly to (0,0) with frame_start.
module vga_sync_gen #(
    parameter int CLK_DIV   = 2,    // system clocks per pixel, 1..16
    parameter int H_DISPLAY = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BP      = 48,
    parameter int V_DISPLAY = 480,
    parameter int V_FP      = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 33
) (
    input  logic           clk,
    input  logic           rst_n,
    vga_sync_gen_if.master vga
);

    localparam int H_TOTAL = H_DISPLAY + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_DISPLAY + V_FP + V_SYNC + V_BP;
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS    = 10'(H_DISPLAY);
    localparam logic [9:0] V_VIS    = 10'(V_DISPLAY);
    localparam logic [9:0] HS_FIRST = 10'(H_DISPLAY + H_FP);
    localparam logic [9:0] HS_LAST  = 10'(H_DISPLAY + H_FP + H_SYNC - 1);
    localparam logic [9:0] VS_FIRST = 10'(V_DISPLAY + V_FP);
    localparam logic [9:0] VS_LAST  = 10'(V_DISPLAY + V_FP + V_SYNC - 1);

    logic [DIV_W-1:0] div_q, div_d;
    logic             p_tick;
    logic [9:0]       h_q, h_d;
    logic [9:0]       v_q, v_d;
    logic             video_on_q, video_on_d;
    logic             hsync_q, hsync_d;
    logic             vsync_q, vsync_d;
    logic             line_start_q, line_start_d;
    logic             frame_start_q, frame_start_d;

    // Next-state counters, then every flag derived from those next-state
    // values so the flags register on the same edge as the coordinates.
    always_comb begin
        p_tick        = (div_q == DIV_LAST);
        div_d         = div_q + 1'b1;
        h_d           = h_q;
        v_d           = v_q;
        if (p_tick) begin
            div_d = '0;
            if (h_q == H_LAST) begin
                h_d = '0;
                // vertical step shares the edge of the horizontal wrap
                if (v_q == V_LAST) begin
                    v_d = '0;
                end else begin
                    v_d = v_q + 10'd1;
                end
            end else begin
                h_d = h_q + 10'd1;
            end
        end
        video_on_d    = (h_d < H_VIS) && (v_d < V_VIS);
        hsync_d       = !((h_d >= HS_FIRST) && (h_d <= HS_LAST));
        vsync_d       = !((v_d >= VS_FIRST) && (v_d <= VS_LAST));
        // only a tick edge can move h to 0, so these last exactly one clk
        line_start_d  = p_tick && (h_d == 10'd0);
        frame_start_d = line_start_d && (v_d == 10'd0);
    end

    // Divider, scan counters and registered flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q         <= '0;
            h_q           <= H_LAST;
            v_q           <= V_LAST;
            video_on_q    <= 1'b0;
            hsync_q       <= 1'b1;
            vsync_q       <= 1'b1;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            div_q         <= div_d;
            h_q           <= h_d;
            v_q           <= v_d;
            video_on_q    <= video_on_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign vga.p_tick      = p_tick;
    assign vga.pixel_x     = h_q;
    assign vga.pixel_y     = v_q;
    assign vga.video_on    = video_on_q;
    assign vga.hsync       = hsync_q;
    assign vga.vsync       = vsync_q;
    assign vga.line_start  = line_start_q;
    assign vga.frame_start = frame_start_q;

endmodule

// File: doc/vga_sync_gen.md
# vga_sync_gen

Timing generator for the VGA text path. It divides the system clock into a pixel tick and runs horizontal and vertical scan counters. From those it produces registered hsync/vsync, the video_on blanking flag and the pixel_x/pixel_y coordinates consumed by the text/font pixel generator directly downstream. The default timing is 640x480 at 60 Hz from a 50 MHz clock with CLK_DIV=2.

## Interface
Parameters:
- CLK_DIV, 2, system clocks per pixel; legal range 1..16
- H_DISPLAY, 640, visible pixels per line
- H_FP, 16, horizontal front porch, in pixels
- H_SYNC, 96, horizontal sync width, in pixels
- H_BP, 48, horizontal back porch, in pixels
- V_DISPLAY, 480, visible lines per frame
- V_FP, 10, vertical front porch, in lines
- V_SYNC, 2, vertical sync width, in lines
- V_BP, 33, vertical back porch, in lines

Ports:
- clk, in, 1, system clock; all state updates on rising edge
- rst_n, in, 1, asynchronous active-low reset
- p_tick, out, 1, one-clk pixel enable
- pixel_x, out, 10, horizontal count, 0..H_TOTAL-1
- pixel_y, out, 10, vertical count, 0..V_TOTAL-1
- video_on, out, 1, high in the visible region
- hsync, out, 1, horizontal sync, active low
- vsync, out, 1, vertical sync, active low
- line_start, out, 1, one-clk pulse when pixel_x becomes 0
- frame_start, out, 1, one-clk pulse when (pixel_x, pixel_y) becomes (0,0)

## Operation
- Totals:
  - H_TOTAL = H_DISPLAY+H_FP+H_SYNC+H_BP (800 by default).
  - V_TOTAL = V_DISPLAY+V_FP+V_SYNC+V_BP (525 by default).
- Divider:
  - div_cnt counts 0..CLK_DIV-1 and wraps to 0.
  - p_tick = (div_cnt == CLK_DIV-1).
  - With CLK_DIV=1, p_tick is constantly 1 after reset.
- Horizontal counter (h) advances only on clock edges where p_tick=1.
  - At H_TOTAL-1 it wraps to 0; otherwise it increments.
- Vertical counter (v) advances on the same edge on which h wraps.
  - At V_TOTAL-1 it wraps to 0; otherwise it increments.
- pixel_x = h and pixel_y = v, both zero-extended to 10 bits.
- All remaining outputs are registered. Each is computed from the next-state counters, so it stays consistent with pixel_x/pixel_y in the same cycle:
  - video_on = (h < H_DISPLAY) && (v < V_DISPLAY).
  - hsync = 0 for h in [H_DISPLAY+H_FP, H_DISPLAY+H_FP+H_SYNC-1], i.e. 656..751 by default; 1 otherwise.
  - vsync = 0 for v in [V_DISPLAY+V_FP, V_DISPLAY+V_FP+V_SYNC-1], i.e. 490..491 by default; 1 otherwise.
  - line_start = 1 for the single clk following an update that sets h to 0.
  - frame_start = 1 for the single clk following an update that sets h and v to 0. line_start is also 1 in that cycle.
- There is no handshake. The downstream stage samples coordinates every clk and may use p_tick as an enable.

## Timing
- Reset state, held while rst_n=0:
  - div_cnt=0, h=H_TOTAL-1, v=V_TOTAL-1, i.e. pixel_x=799, pixel_y=524 by default.
  - video_on=0, hsync=1, vsync=1, line_start=0, frame_start=0.
  - p_tick=0 when CLK_DIV>1; p_tick=1 when CLK_DIV=1.
- This reset point is the last blanking pixel of a frame. The first p_tick after release wraps to (0,0), giving frame_start at the start of a clean frame.
- First p_tick: asserted in clk cycle CLK_DIV after rst_n deasserts, counting the first cycle after release as cycle 1.
- Counters and registered outputs update on the edge that ends the p_tick cycle, so latency from p_tick to new coordinates is 1 clk.
- Periods:
  - line = H_TOTAL*CLK_DIV clks (1600 by default)
  - frame = H_TOTAL*V_TOTAL*CLK_DIV clks (840000 by default)
- Sync pulse widths, in pixel ticks: hsync low for exactly H_SYNC; vsync low for exactly V_SYNC*H_TOTAL.
- Simultaneous wrap of h and v produces a single update: both counters go to 0, and line_start and frame_start pulse together.
- Reset asserted mid-frame forces the reset state immediately (asynchronous), with no glitch once released.
- Pulses never last more than 1 clk, even when CLK_DIV=1.

## Test plan
- Reset/release, CLK_DIV=2:
  - During reset: pixel=(799,524), video_on=0, hsync=vsync=1.
  - First p_tick at release cycle 2; next clk: pixel=(0,0), video_on=1, frame_start=1, line_start=1.
- Horizontal timing:
  - Over one line, count p_ticks with hsync=0: exactly 96, starting at pixel_x=656.
  - video_on=1 for pixel_x 0..639 on visible lines.
  - Line period is 1600 clks.
- Vertical timing:
  - vsync=0 exactly on pixel_y 490..491, i.e. 1600 p_ticks.
  - video_on=0 for pixel_y 480..524.
  - Consecutive frame_start pulses are 840000 clks apart.
- Visible pixel count: exactly 307200 p_ticks with video_on=1 per frame, and one frame_start per frame.
- Mid-frame reset: assert rst_n=0 at pixel (300,200) for 3 clks.
  - Outputs return to the reset state within the same cycle.
  - After release, the next frame starts at (0,0) with frame_start.
- CLK_DIV=1, small parameters (H 8/1/2/1, V 4/1/1/1):
  - p_tick is constant 1.
  - Wrap 11→0 and 6→0 occurs on one edge.
  - line_start and frame_start pulse once per wrap.
